// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: signal bundle between the memory stage, the access
// unit and the data memory. "slave" is the access unit's view; "master" is
// the surrounding pipeline/memory environment.
interface dmem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int LANES = DATA_W / 8;

    logic              Read;
    logic              Write;
    logic [1:0]        Size;
    logic              SignExtend;
    logic              LLSC;
    logic              ERET;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] MReadData;
    logic              DataMem_Ack;
    logic [ADDR_W-1:0] MAddress;
    logic [DATA_W-1:0] MWriteData;
    logic [LANES-1:0]  ByteEnable;
    logic              ReadEnable;
    logic              WriteEnable;
    logic [DATA_W-1:0] DataOut;
    logic              M_Stall;
    logic              EXC_AdEL;
    logic              EXC_AdES;
    logic              EXC_Timeout;

    modport master (
        output Read, Write, Size, SignExtend, LLSC, ERET, Address, DataIn,
               MReadData, DataMem_Ack,
        input  MAddress, MWriteData, ByteEnable, ReadEnable, WriteEnable,
               DataOut, M_Stall, EXC_AdEL, EXC_AdES, EXC_Timeout
    );

    modport slave (
        input  Read, Write, Size, SignExtend, LLSC, ERET, Address, DataIn,
               MReadData, DataMem_Ack,
        output MAddress, MWriteData, ByteEnable, ReadEnable, WriteEnable,
               DataOut, M_Stall, EXC_AdEL, EXC_AdES, EXC_Timeout
    );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: data-memory access controller for the memory stage.
// Handles byte-lane steering, alignment exceptions, a variable-latency
// Ack handshake with optional timeout, and an LL/SC reservation.
module dmem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int LLSC_EN = 1
) (
    input logic               CLK,
    input logic               RST,
    dmem_access_unit_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [LANES-1:0]    be_q, be_d;
    logic                re_q, re_d, we_q, we_d, tmo_q, tmo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LB-1:0]       lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                sext_q, sext_d, ll_q, ll_d, sc_q, sc_d;
    logic                resv_vld_q, resv_vld_d;
    logic [ADDR_W-LB-1:0] resv_addr_q, resv_addr_d;

    logic req_ld, req_st, misaligned, resv_hit, sc_ok;
    logic stall, adel, ades;

    function automatic int size_bytes(input logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        if (nb > LANES) nb = LANES;
        return nb;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            default: return (DATA_W == 32) || (a != 3'b000);
        endcase
    endfunction

    function automatic logic [LANES-1:0] lane_strobes(input logic [1:0] sz, input logic [LB-1:0] l);
        logic [LANES-1:0] s;
        int nb;
        nb = size_bytes(sz);
        for (int i = 0; i < LANES; i++)
            s[i] = (i >= int'(l)) && (i < int'(l) + nb);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d, input logic [1:0] sz);
        logic [DATA_W-1:0] r;
        int nb;
        nb = size_bytes(sz);
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = d[8*(i % nb) +: 8];
        return r;
    endfunction

    // Shift the addressed lane down, then push it to the top and back so the
    // right-shift fills the upper bits with either zeros or its sign bit.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [LB-1:0] l,
                                                      input logic [1:0] sz,
                                                      input logic sx);
        logic [DATA_W-1:0]        sh;
        logic signed [DATA_W-1:0] sh_s;
        int k;
        k    = DATA_W - 8 * size_bytes(sz);
        sh   = (raw >> {l, 3'b000}) << k;
        sh_s = sh;
        if (sx) begin
            sh_s = sh_s >>> k;
            return sh_s;
        end
        return sh >> k;
    endfunction

    assign req_ld     = bus.Read;
    assign req_st     = bus.Write & ~bus.Read;
    assign misaligned = is_misaligned(bus.Size, bus.Address[2:0]);
    assign resv_hit   = resv_vld_q && (bus.Address[ADDR_W-1:LB] == resv_addr_q);
    assign sc_ok      = (LLSC_EN != 0) && resv_hit;

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            maddr_q     <= '0;
            wdata_q     <= '0;
            dout_q      <= '0;
            be_q        <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            tmo_q       <= 1'b0;
            cnt_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            ll_q        <= 1'b0;
            sc_q        <= 1'b0;
            resv_vld_q  <= 1'b0;
            resv_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            maddr_q     <= maddr_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            be_q        <= be_d;
            re_q        <= re_d;
            we_q        <= we_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            ll_q        <= ll_d;
            sc_q        <= sc_d;
            resv_vld_q  <= resv_vld_d;
            resv_addr_q <= resv_addr_d;
        end
    end

    // Next-state, request decode, completion/timeout handling and reservation.
    always_comb begin
        state_d     = state_q;
        maddr_d     = maddr_q;
        wdata_d     = wdata_q;
        dout_d      = dout_q;
        be_d        = be_q;
        re_d        = re_q;
        we_d        = we_q;
        tmo_d       = 1'b0;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        size_d      = size_q;
        sext_d      = sext_q;
        ll_d        = ll_q;
        sc_d        = sc_q;
        resv_vld_d  = resv_vld_q;
        resv_addr_d = resv_addr_q;
        stall       = 1'b0;
        adel        = 1'b0;
        ades        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_ld || req_st) begin
                    if (misaligned) begin
                        adel = req_ld;
                        ades = req_st;
                    end else begin
                        stall   = 1'b1;
                        maddr_d = {bus.Address[ADDR_W-1:LB], {LB{1'b0}}};
                        lane_d  = bus.Address[LB-1:0];
                        size_d  = bus.Size;
                        sext_d  = bus.SignExtend;
                        ll_d    = req_ld & bus.LLSC;
                        sc_d    = req_st & bus.LLSC;
                        cnt_d   = '0;
                        if (req_ld) begin
                            re_d    = 1'b1;
                            be_d    = '0;
                            state_d = WAIT;
                        end else begin
                            if (bus.LLSC || resv_hit) resv_vld_d = 1'b0;
                            if (bus.LLSC && !sc_ok) begin
                                dout_d  = '0;
                                state_d = DONE;
                            end else begin
                                we_d    = 1'b1;
                                be_d    = lane_strobes(bus.Size, bus.Address[LB-1:0]);
                                wdata_d = replicate(bus.DataIn, bus.Size);
                                state_d = WAIT;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (bus.DataMem_Ack) begin
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    state_d = DONE;
                    if (re_q) dout_d = load_extend(bus.MReadData, lane_q, size_q, sext_q);
                    else      dout_d = sc_q ? DATA_W'(1) : '0;
                    if (re_q && ll_q && (LLSC_EN != 0)) begin
                        resv_vld_d  = 1'b1;
                        resv_addr_d = maddr_q[ADDR_W-1:LB];
                    end
                end else if ((TIMEOUT != 0) && (cnt_q + 1'b1 == CNT_LIM)) begin
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    be_d    = '0;
                    dout_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.ERET) resv_vld_d = 1'b0;
    end

    assign bus.MAddress    = maddr_q;
    assign bus.MWriteData  = wdata_q;
    assign bus.ByteEnable  = be_q;
    assign bus.ReadEnable  = re_q;
    assign bus.WriteEnable = we_q;
    assign bus.DataOut     = dout_q;
    assign bus.EXC_Timeout = tmo_q;
    assign bus.M_Stall     = RST & stall;
    assign bus.EXC_AdEL    = RST & adel;
    assign bus.EXC_AdES    = RST & ades;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed vector bench for dmem_access_unit
// (DATA_W=32, TIMEOUT=4, LLSC enabled).
module tb_dmem_access_unit;
    logic CLK;
    logic RST;

    dmem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_access_unit #(
        .DATA_W (32),
        .ADDR_W (32),
        .TIMEOUT(4),
        .LLSC_EN(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        bit [1:0]    sz;
        bit          sx;
        bit          ll;
        bit [31:0]   addr;
        bit [31:0]   din;
        bit [31:0]   rdata;
        int          ack;      // cycles after the enable rises; -1 = never
        bit          adel;
        bit          ades;
        int          n_stall;
        int          n_re;
        int          n_we;
        bit [31:0]   maddr;
        bit [3:0]    be;
        bit [31:0]   wdata;
        bit [31:0]   dout;
        int          n_tmo;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Read        = 1'b0;
        bus.Write       = 1'b0;
        bus.Size        = 2'd0;
        bus.SignExtend  = 1'b0;
        bus.LLSC        = 1'b0;
        bus.Address     = '0;
        bus.DataIn      = '0;
        bus.MReadData   = '0;
        bus.DataMem_Ack = 1'b0;
    endtask

    // Starts and ends at posedge+1.
    task automatic run_vec(input vec_t v);
        int cyc, n_st, n_re, n_we, n_tmo;
        bit done, cap, moved;
        logic [31:0] c_ma, c_wd, dout_s;
        logic [3:0]  c_be;
        bus.Read        = v.rd;
        bus.Write       = v.wr;
        bus.Size        = v.sz;
        bus.SignExtend  = v.sx;
        bus.LLSC        = v.ll;
        bus.Address     = v.addr;
        bus.DataIn      = v.din;
        bus.MReadData   = v.rdata;
        bus.DataMem_Ack = 1'b0;
        if (v.adel || v.ades) begin
            @(negedge CLK);
            check({v.name, ".adel"}, bus.EXC_AdEL, v.adel);
            check({v.name, ".ades"}, bus.EXC_AdES, v.ades);
            check({v.name, ".stall"}, bus.M_Stall, 0);
            @(posedge CLK); #1;
            check({v.name, ".no_strobe"}, {bus.ReadEnable, bus.WriteEnable, bus.M_Stall}, 0);
        end else begin
            cyc = 0; done = 0; cap = 0; moved = 0;
            n_st = 0; n_re = 0; n_we = 0; n_tmo = 0;
            c_ma = '0; c_wd = '0; c_be = '0; dout_s = '0;
            while (!done && cyc < 30) begin
                bus.DataMem_Ack = (v.ack >= 0) && (cyc == v.ack + 1);
                @(negedge CLK);
                if (bus.M_Stall)     n_st++;
                if (bus.ReadEnable)  n_re++;
                if (bus.WriteEnable) n_we++;
                if (bus.EXC_Timeout) n_tmo++;
                if (bus.ReadEnable || bus.WriteEnable) begin
                    if (!cap) begin
                        c_ma = bus.MAddress;
                        c_be = bus.ByteEnable;
                        c_wd = bus.MWriteData;
                        cap  = 1;
                    end else if (c_ma !== bus.MAddress || c_be !== bus.ByteEnable ||
                                 c_wd !== bus.MWriteData) begin
                        moved = 1;
                    end
                end
                if (!bus.M_Stall) begin
                    done   = 1;
                    dout_s = bus.DataOut;
                end
                @(posedge CLK); #1;
                cyc++;
            end
            bus.DataMem_Ack = 1'b0;
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL %s.bound stall still high after 30 cycles", v.name);
            end
            check({v.name, ".stall_cycles"}, n_st, v.n_stall);
            check({v.name, ".re_cycles"}, n_re, v.n_re);
            check({v.name, ".we_cycles"}, n_we, v.n_we);
            check({v.name, ".tmo_pulses"}, n_tmo, v.n_tmo);
            check({v.name, ".dout"}, dout_s, v.dout);
            if (v.n_re + v.n_we > 0) begin
                check({v.name, ".maddr"}, c_ma, v.maddr);
                check({v.name, ".be"}, c_be, v.be);
                check({v.name, ".stable"}, moved, 0);
            end
            if (v.n_we > 0) check({v.name, ".wdata"}, c_wd, v.wdata);
        end
        idle_inputs();
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b0;
        bus.ERET = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        check("reset.maddr", bus.MAddress, 0);
        check("reset.wdata", bus.MWriteData, 0);
        check("reset.be",    bus.ByteEnable, 0);
        check("reset.re_we", {bus.ReadEnable, bus.WriteEnable}, 0);
        check("reset.dout",  bus.DataOut, 0);
        check("reset.stall", bus.M_Stall, 0);
        check("reset.exc",   {bus.EXC_AdEL, bus.EXC_AdES, bus.EXC_Timeout}, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        //            name             rd wr sz sx ll addr          din           rdata         ack adel ades st re we maddr         be    wdata         dout          tmo
        vecs.push_back('{"lw_ack3",      1, 0, 2, 0, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 3, 0, 0, 5, 4, 0, 32'h00000100, 4'h0, 32'h0,        32'hDEADBEEF, 0});
        vecs.push_back('{"sb_lane3",     0, 1, 0, 0, 0, 32'h00001003, 32'h000000AB, 32'h0,        1, 0, 0, 3, 0, 2, 32'h00001000, 4'h8, 32'hABABABAB, 32'h0,        0});
        vecs.push_back('{"lb_signed",    1, 0, 0, 1, 0, 32'h00002001, 32'h0,        32'h00008000, 0, 0, 0, 2, 1, 0, 32'h00002000, 4'h0, 32'h0,        32'hFFFFFF80, 0});
        vecs.push_back('{"lb_unsigned",  1, 0, 0, 0, 0, 32'h00002001, 32'h0,        32'h00008000, 0, 0, 0, 2, 1, 0, 32'h00002000, 4'h0, 32'h0,        32'h00000080, 0});
        vecs.push_back('{"lw_misalign",  1, 0, 2, 0, 0, 32'h00001002, 32'h0,        32'h0,        0, 1, 0, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0});
        vecs.push_back('{"sd_illegal",   0, 1, 3, 0, 0, 32'h00001000, 32'h0,        32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0});
        vecs.push_back('{"sh_misalign",  0, 1, 1, 0, 0, 32'h00002001, 32'h0,        32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0});
        vecs.push_back('{"sh_lane2",     0, 1, 1, 0, 0, 32'h00002002, 32'h1234ABCD, 32'h0,        0, 0, 0, 2, 0, 1, 32'h00002000, 4'hC, 32'hABCDABCD, 32'h0,        0});
        vecs.push_back('{"lh_signed",    1, 0, 1, 1, 0, 32'h00003002, 32'h0,        32'h80010000, 2, 0, 0, 4, 3, 0, 32'h00003000, 4'h0, 32'h0,        32'hFFFF8001, 0});
        vecs.push_back('{"rd_wr_both",   1, 1, 2, 0, 0, 32'h00000044, 32'h00000055, 32'h11223344, 0, 0, 0, 2, 1, 0, 32'h00000044, 4'h0, 32'h0,        32'h11223344, 0});
        vecs.push_back('{"lw_timeout",   1, 0, 2, 0, 0, 32'h00000500, 32'h0,        32'h0,       -1, 0, 0, 5, 4, 0, 32'h00000500, 4'h0, 32'h0,        32'h0,        1});
        vecs.push_back('{"ll_40",        1, 0, 2, 0, 1, 32'h00000040, 32'h0,        32'h00000005, 0, 0, 0, 2, 1, 0, 32'h00000040, 4'h0, 32'h0,        32'h00000005, 0});
        vecs.push_back('{"sc_40_ok",     0, 1, 2, 0, 1, 32'h00000040, 32'h00000007, 32'h0,        0, 0, 0, 2, 0, 1, 32'h00000040, 4'hF, 32'h00000007, 32'h00000001, 0});
        vecs.push_back('{"sc_40_again",  0, 1, 2, 0, 1, 32'h00000040, 32'h00000007, 32'h0,       -1, 0, 0, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0});
        vecs.push_back('{"ll_40_b",      1, 0, 2, 0, 1, 32'h00000040, 32'h0,        32'h00000009, 0, 0, 0, 2, 1, 0, 32'h00000040, 4'h0, 32'h0,        32'h00000009, 0});
        vecs.push_back('{"sw_40_clear",  0, 1, 2, 0, 0, 32'h00000040, 32'h00000077, 32'h0,        0, 0, 0, 2, 0, 1, 32'h00000040, 4'hF, 32'h00000077, 32'h0,        0});
        vecs.push_back('{"sc_40_fail",   0, 1, 2, 0, 1, 32'h00000040, 32'h00000007, 32'h0,       -1, 0, 0, 1, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0});

        foreach (vecs[i]) run_vec(vecs[i]);

        // ERET pulse between LL and SC drops the reservation.
        v = '{"ll_80", 1, 0, 2, 0, 1, 32'h80, 32'h0, 32'h5, 0, 0, 0, 2, 1, 0, 32'h80, 4'h0, 32'h0, 32'h5, 0};
        run_vec(v);
        bus.ERET = 1'b1;
        @(posedge CLK); #1;
        bus.ERET = 1'b0;
        v = '{"sc_80_eret", 0, 1, 2, 0, 1, 32'h80, 32'h3, 32'h0, -1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        run_vec(v);

        // ERET held across the LL completion wins over the set.
        bus.ERET = 1'b1;
        v = '{"ll_90_eret", 1, 0, 2, 0, 1, 32'h90, 32'h0, 32'h6, 1, 0, 0, 3, 2, 0, 32'h90, 4'h0, 32'h0, 32'h6, 0};
        run_vec(v);
        bus.ERET = 1'b0;
        v = '{"sc_90_fail", 0, 1, 2, 0, 1, 32'h90, 32'h3, 32'h0, -1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        run_vec(v);

        // Reset in the middle of a WAIT: everything clears at once.
        v = '{"ll_c0", 1, 0, 2, 0, 1, 32'hC0, 32'h0, 32'h5A, 0, 0, 0, 2, 1, 0, 32'hC0, 4'h0, 32'h0, 32'h5A, 0};
        run_vec(v);
        bus.Read    = 1'b1;
        bus.Size    = 2'd2;
        bus.Address = 32'h600;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_mid.pre_re", bus.ReadEnable, 1);
        check("rst_mid.pre_stall", bus.M_Stall, 1);
        #1 RST = 1'b0;
        #1;
        check("rst_mid.maddr", bus.MAddress, 0);
        check("rst_mid.wdata", bus.MWriteData, 0);
        check("rst_mid.be_re_we", {bus.ByteEnable, bus.ReadEnable, bus.WriteEnable}, 0);
        check("rst_mid.dout", bus.DataOut, 0);
        check("rst_mid.stall", bus.M_Stall, 0);
        check("rst_mid.exc", {bus.EXC_AdEL, bus.EXC_AdES, bus.EXC_Timeout}, 0);
        @(posedge CLK); #1;
        bus.Read = 1'b0;
        RST      = 1'b1;
        @(negedge CLK);
        check("rst_mid.idle_after", {bus.ReadEnable, bus.WriteEnable, bus.M_Stall, bus.EXC_Timeout}, 0);
        @(posedge CLK); #1;
        v = '{"sc_c0_after_rst", 0, 1, 2, 0, 1, 32'hC0, 32'h3, 32'h0, -1, 0, 0, 1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        run_vec(v);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
